// File: rtl/tr_ctrl_pkg.sv
// Shared definitions for the transfer register sequencer: opcodes, FSM states,
// strobe bit positions and opcode decode helpers.
package tr_ctrl_pkg;

  localparam int NUM_PORTS = 2;
  localparam int OP_W      = 4;

  localparam logic [OP_W-1:0] OP_NOP      = 4'd0;
  localparam logic [OP_W-1:0] OP_LD_L     = 4'd1;
  localparam logic [OP_W-1:0] OP_LD_H     = 4'd2;
  localparam logic [OP_W-1:0] OP_LD_W     = 4'd3;
  localparam logic [OP_W-1:0] OP_ST_L     = 4'd4;
  localparam logic [OP_W-1:0] OP_ST_H     = 4'd5;
  localparam logic [OP_W-1:0] OP_ST_W     = 4'd6;
  localparam logic [OP_W-1:0] OP_LD_X     = 4'd7;
  localparam logic [OP_W-1:0] OP_DRV_ADDR = 4'd8;
  localparam logic [OP_W-1:0] OP_DRV_XFER = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    TURN  = 2'd3
  } tr_state_e;

  localparam int STB_W      = 7;
  localparam int STB_L_TL   = 0;
  localparam int STB_L_TH   = 1;
  localparam int STB_L_TX   = 2;
  localparam int STB_A_TL   = 3;
  localparam int STB_A_TH   = 4;
  localparam int STB_A_ADDR = 5;
  localparam int STB_A_XFER = 6;

  // Active-high one-hot of the strobe driven in the first beat; zero for NOP/reserved.
  function automatic logic [STB_W-1:0] first_beat_stb(input logic [OP_W-1:0] op);
    logic [STB_W-1:0] s;
    s = '0;
    case (op)
      OP_LD_L, OP_LD_W: s[STB_L_TL]   = 1'b1;
      OP_LD_H:          s[STB_L_TH]   = 1'b1;
      OP_ST_L, OP_ST_W: s[STB_A_TL]   = 1'b1;
      OP_ST_H:          s[STB_A_TH]   = 1'b1;
      OP_LD_X:          s[STB_L_TX]   = 1'b1;
      OP_DRV_ADDR:      s[STB_A_ADDR] = 1'b1;
      OP_DRV_XFER:      s[STB_A_XFER] = 1'b1;
      default:          s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [STB_W-1:0] second_beat_stb(input logic [OP_W-1:0] op);
    logic [STB_W-1:0] s;
    s = '0;
    case (op)
      OP_LD_W: s[STB_L_TH] = 1'b1;
      OP_ST_W: s[STB_A_TH] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic is_word(input logic [OP_W-1:0] op);
    return (op == OP_LD_W) || (op == OP_ST_W);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_ST_L) || (op == OP_ST_H) || (op == OP_ST_W);
  endfunction

endpackage

// File: rtl/tr_ctrl_arb.sv
// Two-port request arbiter. Fixed priority to port 0 by default; define
// TR_CTRL_RR_EN for round-robin with a 1-bit last-grant pointer.
module tr_ctrl_arb
  import tr_ctrl_pkg::*;
(
`ifdef TR_CTRL_RR_EN
  input  logic                 clk,
  input  logic                 rst_n,
`endif
  input  logic [NUM_PORTS-1:0] i_valid,
  input  logic                 i_enable,
  output logic [NUM_PORTS-1:0] o_grant
);

`ifdef TR_CTRL_RR_EN
  // r_ptr names the port that wins the next tie
  logic r_ptr;

  always_comb begin
    o_grant = '0;
    if (i_enable) begin
      if (&i_valid) o_grant = r_ptr ? 2'b10 : 2'b01;
      else          o_grant = i_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ptr <= 1'b0;
    else if (|o_grant) r_ptr <= o_grant[0];
  end
`else
  always_comb begin
    o_grant = '0;
    if (i_enable) begin
      if (i_valid[0])      o_grant = 2'b01;
      else if (i_valid[1]) o_grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/transfer_register_ctrl.sv
// Sequencer for the 16-bit transfer register: arbitrates two requesters and
// issues registered active-low strobes. Optional macro: TR_CTRL_RR_EN.
module transfer_register_ctrl
  import tr_ctrl_pkg::*;
#(
  parameter int TURN_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [OP_W-1:0] req0_op,
  input  logic            req1_valid,
  input  logic [OP_W-1:0] req1_op,
  output logic            req0_ready,
  output logic            req1_ready,
  output logic            req0_done,
  output logic            req1_done,
  output logic            busy,
  output logic            l_tl_n,
  output logic            l_th_n,
  output logic            l_tx_n,
  output logic            a_tl_n,
  output logic            a_th_n,
  output logic            a_tx_addr_n,
  output logic            a_tx_xfer_n
);

  localparam logic       TURN_EN   = (TURN_CYCLES > 0);
  localparam logic [1:0] TURN_LOAD = (TURN_CYCLES > 0) ? 2'(TURN_CYCLES - 1) : 2'd0;

  tr_state_e             r_state, w_state_nxt;
  logic [OP_W-1:0]       r_op, w_op_nxt, w_op_sel;
  logic                  r_port, w_port_nxt;
  logic [STB_W-1:0]      r_stb_n, w_stb_n_nxt;
  logic [NUM_PORTS-1:0]  r_done, w_done_nxt;
  logic [1:0]            r_turn_cnt, w_turn_nxt;
  logic                  r_run;
  logic                  w_enable;
  logic                  w_complete;
  logic [NUM_PORTS-1:0]  w_grant;

  // r_run keeps ready low until the first clock edge after reset release
  assign w_enable = (r_state == IDLE) && r_run;
  assign w_op_sel = w_grant[1] ? req1_op : req0_op;

  tr_ctrl_arb u_arb (
`ifdef TR_CTRL_RR_EN
    .clk      (clk),
    .rst_n    (rst_n),
`endif
    .i_valid  ({req1_valid, req0_valid}),
    .i_enable (w_enable),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_port_nxt  = r_port;
    w_stb_n_nxt = '1;
    w_done_nxt  = '0;
    w_turn_nxt  = r_turn_cnt;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_port_nxt  = w_grant[1];
          w_op_nxt    = w_op_sel;
          w_stb_n_nxt = ~first_beat_stb(w_op_sel);
          w_state_nxt = BEAT1;
        end
      end
      BEAT1: begin
        if (is_word(r_op)) begin
          w_stb_n_nxt = ~second_beat_stb(r_op);
          w_state_nxt = BEAT2;
        end else begin
          w_complete = 1'b1;
        end
      end
      BEAT2: w_complete = 1'b1;
      TURN: begin
        if (r_turn_cnt == 2'd0) w_state_nxt = IDLE;
        else                    w_turn_nxt  = r_turn_cnt - 2'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Stores leave MainBus driven, so they pay the turnaround before the next grant
    if (w_complete) begin
      w_done_nxt[r_port] = 1'b1;
      if (TURN_EN && is_store(r_op)) begin
        w_state_nxt = TURN;
        w_turn_nxt  = TURN_LOAD;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= OP_NOP;
      r_port     <= 1'b0;
      r_stb_n    <= '1;
      r_done     <= '0;
      r_turn_cnt <= '0;
      r_run      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_port     <= w_port_nxt;
      r_stb_n    <= w_stb_n_nxt;
      r_done     <= w_done_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_run      <= 1'b1;
    end
  end

  assign req0_ready  = w_grant[0];
  assign req1_ready  = w_grant[1];
  assign req0_done   = r_done[0];
  assign req1_done   = r_done[1];
  assign busy        = (r_state != IDLE);
  assign l_tl_n      = r_stb_n[STB_L_TL];
  assign l_th_n      = r_stb_n[STB_L_TH];
  assign l_tx_n      = r_stb_n[STB_L_TX];
  assign a_tl_n      = r_stb_n[STB_A_TL];
  assign a_th_n      = r_stb_n[STB_A_TH];
  assign a_tx_addr_n = r_stb_n[STB_A_ADDR];
  assign a_tx_xfer_n = r_stb_n[STB_A_XFER];

endmodule

// File: tb/tb_transfer_register_ctrl.sv
// Self-checking bench for transfer_register_ctrl: schedule-based reference model
// compared every cycle, plus directed literal checks and a random command stream.
module tb_transfer_register_ctrl;

  localparam int TC = 2;
`ifdef TR_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       tv  [2];
  logic [3:0] top [2];
  logic       req0_valid, req1_valid;
  logic [3:0] req0_op, req1_op;
  logic       req0_ready, req1_ready, req0_done, req1_done, busy;
  logic       l_tl_n, l_th_n, l_tx_n, a_tl_n, a_th_n, a_tx_addr_n, a_tx_xfer_n;

  assign req0_valid = tv[0];
  assign req1_valid = tv[1];
  assign req0_op    = top[0];
  assign req1_op    = top[1];

  transfer_register_ctrl #(.TURN_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_op(req1_op),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_done(req0_done), .req1_done(req1_done), .busy(busy),
    .l_tl_n(l_tl_n), .l_th_n(l_th_n), .l_tx_n(l_tx_n),
    .a_tl_n(a_tl_n), .a_th_n(a_th_n),
    .a_tx_addr_n(a_tx_addr_n), .a_tx_xfer_n(a_tx_xfer_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: 0 l_tl, 1 l_th, 2 l_tx, 3 a_tl, 4 a_th, 5 a_addr, 6 a_xfer
  logic [6:0] obs;
  assign obs = {a_tx_xfer_n, a_tx_addr_n, a_th_n, a_tl_n, l_tx_n, l_th_n, l_tl_n};

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_grant = 0;
  logic m_run = 1'b0;
  logic took [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Strobes used by each opcode (-1: none)
  task automatic op_beats(input logic [3:0] op, output int b1, output int b2);
    b1 = -1; b2 = -1;
    case (op)
      4'd1: b1 = 0;
      4'd2: b1 = 1;
      4'd3: begin b1 = 0; b2 = 1; end
      4'd4: b1 = 3;
      4'd5: b1 = 4;
      4'd6: begin b1 = 3; b2 = 4; end
      4'd7: b1 = 2;
      4'd8: b1 = 5;
      4'd9: b1 = 6;
      default: ;
    endcase
  endtask

  function automatic logic [6:0] low_mask(input int b);
    logic [6:0] one;
    one = 7'h01;
    if (b < 0) return 7'h7F;
    return 7'h7F & ~(one << b);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_run <= 1'b0;
    else        m_run <= 1'b1;
  end

  // Reference model: a grant in cycle c books strobes and done in future cycles
  logic [6:0] exp_stb  [int];
  logic [1:0] exp_done [int];
  int         m_avail = 0;
  logic       m_ptr   = 1'b0;
  logic [1:0] eg, ed;
  logic [6:0] es;
  logic       eb;
  int         b1, b2, gp, dcyc;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready",   {30'd0, req1_ready, req0_ready}, 0);
      chk("rst_busy",    {31'd0, busy}, 0);
      chk("rst_strobes", {25'd0, obs}, 32'h7F);
      chk("rst_done",    {30'd0, req1_done, req0_done}, 0);
      exp_stb.delete();
      exp_done.delete();
      m_avail = 0;
      m_ptr   = 1'b0;
    end else begin
      eb = (cyc < m_avail);
      eg = 2'b00;
      if (m_run && cyc >= m_avail) begin
        if (tv[0] && tv[1]) eg = (RR && m_ptr) ? 2'b10 : 2'b01;
        else                eg = {tv[1], tv[0]};
      end
      es = exp_stb.exists(cyc)  ? exp_stb[cyc]  : 7'h7F;
      ed = exp_done.exists(cyc) ? exp_done[cyc] : 2'b00;
      chk("ready",   {30'd0, req1_ready, req0_ready}, {30'd0, eg});
      chk("busy",    {31'd0, busy}, {31'd0, eb});
      chk("strobes", {25'd0, obs}, {25'd0, es});
      chk("done",    {30'd0, req1_done, req0_done}, {30'd0, ed});
      chk("one_strobe_low", {31'd0, ($countones(~obs) <= 1)}, 1);
      chk("l_a_exclusive", {31'd0, ((~obs[2:0]) != 3'd0) && ((~obs[6:3]) != 4'd0)}, 0);
      if (eg != 2'b00) begin
        gp = eg[1] ? 1 : 0;
        op_beats(top[gp], b1, b2);
        exp_stb[cyc+1] = low_mask(b1);
        if (b2 >= 0) exp_stb[cyc+2] = low_mask(b2);
        dcyc = cyc + ((b2 >= 0) ? 3 : 2);
        exp_done[dcyc] = (exp_done.exists(dcyc) ? exp_done[dcyc] : 2'b00) | (gp == 1 ? 2'b10 : 2'b01);
        m_avail = dcyc + ((top[gp] >= 4'd4 && top[gp] <= 4'd6) ? TC : 0);
        m_ptr = (gp == 0);
        took[gp] = 1'b1;
        n_grant++;
      end
      if (exp_stb.exists(cyc))  exp_stb.delete(cyc);
      if (exp_done.exists(cyc)) exp_done.delete(cyc);
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; tv[0] = 1'b0; tv[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic issue(input int p, input logic [3:0] op);
    logic ok;
    @(posedge clk); #1;
    tv[p] = 1'b1; top[p] = op; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin ok = 1'b1; break; end
    end
    if (!ok) chk("grant_timeout", 0, 1);
    @(posedge clk); #1;
    tv[p] = 1'b0;
  endtask

  int g [4];
  int k, d1, r0;

  initial begin
    rst_n = 1'b0;
    tv[0] = 1'b0; tv[1] = 1'b0; top[0] = 4'd0; top[1] = 4'd0;
    took[0] = 1'b0; took[1] = 1'b0;

    // Reset held with a pending LD_W, then release and reset mid beat 1
    @(posedge clk); #1;
    tv[0] = 1'b1; top[0] = 4'd3;
    @(negedge clk);
    chk("lit_reset_ready", {31'd0, req0_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_ready_first_cycle", {31'd0, req0_ready}, 0);
    @(negedge clk);
    chk("lit_ready_next_cycle", {31'd0, req0_ready}, 1);
    @(posedge clk); #2;
    chk("lit_ldw_beat1_low", {31'd0, l_tl_n}, 0);
    rst_n = 1'b0;
    #1;
    chk("lit_async_strobes", {25'd0, obs}, 32'h7F);
    chk("lit_async_busy", {31'd0, busy}, 0);
    chk("lit_async_done", {30'd0, req1_done, req0_done}, 0);
    tv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Word load on port 0
    issue(0, 4'd3);
    @(negedge clk);
    chk("lit_ldw_c1_tl", {31'd0, l_tl_n}, 0);
    chk("lit_ldw_c1_th", {31'd0, l_th_n}, 1);
    @(negedge clk);
    chk("lit_ldw_c2_tl", {31'd0, l_tl_n}, 1);
    chk("lit_ldw_c2_th", {31'd0, l_th_n}, 0);
    chk("lit_ldw_c2_done", {31'd0, req0_done}, 0);
    @(negedge clk);
    chk("lit_ldw_c3_done", {31'd0, req0_done}, 1);
    chk("lit_ldw_c3_strobes", {25'd0, obs}, 32'h7F);

    // Store turnaround with a pending load behind it
    apply_reset();
    issue(1, 4'd6);
    tv[0] = 1'b1; top[0] = 4'd1;
    d1 = -1; r0 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req1_done && d1 < 0) d1 = cyc;
      if (req0_ready) begin r0 = cyc; break; end
    end
    @(posedge clk); #1;
    tv[0] = 1'b0;
    chk("lit_turn_seen", {31'd0, (d1 >= 0 && r0 >= 0)}, 1);
    chk("lit_turn_gap", r0 - d1, TC);

    // Arbitration with both ports streaming LD_X
    apply_reset();
    @(posedge clk); #1;
    tv[0] = 1'b1; tv[1] = 1'b1; top[0] = 4'd7; top[1] = 4'd7;
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin g[k] = req1_ready ? 1 : 0; k++; end
    end
    @(posedge clk); #1;
    tv[0] = 1'b0; tv[1] = 1'b0;
    chk("lit_arb_count", k, 4);
    chk("lit_arb_g0", g[0], 0);
    chk("lit_arb_g1", g[1], RR ? 1 : 0);
    chk("lit_arb_g2", g[2], 0);
    chk("lit_arb_g3", g[3], RR ? 1 : 0);

    // Reserved opcode behaves as NOP
    issue(0, 4'd12);
    @(negedge clk);
    chk("lit_rsv_strobes", {25'd0, obs}, 32'h7F);
    chk("lit_rsv_done_early", {31'd0, req0_done}, 0);
    @(negedge clk);
    chk("lit_rsv_done", {31'd0, req0_done}, 1);

    // Random command stream on both ports
    took[0] = 1'b0; took[1] = 1'b0;
    k = n_grant;
    for (int i = 0; i < 20000 && (n_grant - k) < 1000; i++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!tv[p] || took[p]) begin
          took[p] = 1'b0;
          if ($urandom_range(0, 3) != 0) begin
            tv[p] = 1'b1; top[p] = 4'($urandom_range(0, 15));
          end else begin
            tv[p] = 1'b0;
          end
        end
      end
    end
    chk("random_grants_reached", {31'd0, (n_grant - k) >= 1000}, 1);
    tv[0] = 1'b0; tv[1] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
